// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Purpose  : Shares one single-port synchronous RAM between a write        |
// |            requester and a read requester using level req / pulse ack    |
// |            handshakes. All outputs are registered.                       |
// | Options  : ARB_ROUND_ROBIN_EN - alternate grants under contention        |
// |            (default: write always wins a contended IDLE cycle)           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               w_req,
  input  logic [A_WIDTH-1:0] w_addr,
  input  logic [D_WIDTH-1:0] w_data,
  output logic               w_ack,
  input  logic               r_req,
  input  logic [A_WIDTH-1:0] r_addr,
  output logic               r_ack,
  output logic [D_WIDTH-1:0] r_data,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_wen,
  output logic               mem_ren,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WR      = 3'd1;
  localparam logic [2:0] c_RD      = 3'd2;
  localparam logic [2:0] c_RD_WAIT = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;

  logic [2:0] r_state;
  logic       w_write_first;
  logic       w_grant_write;
  logic       w_grant_read;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic c_GRANT_READ  = 1'b0;
  localparam logic c_GRANT_WRITE = 1'b1;

  logic r_last_grant;

  // Remember which port won the most recent grant so contention alternates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last_grant <= c_GRANT_READ;
    end else if (r_state == c_IDLE) begin
      if (w_grant_write) begin
        r_last_grant <= c_GRANT_WRITE;
      end else if (w_grant_read) begin
        r_last_grant <= c_GRANT_READ;
      end
    end
  end

  // Under contention favour the port that did not win last time.
  always_comb begin
    w_write_first = (r_last_grant == c_GRANT_READ);
  end
`else
  // Fixed priority: a pending UART byte must never be lost.
  always_comb begin
    w_write_first = 1'b1;
  end
`endif

  // Grant decision, only acted upon in IDLE.
  always_comb begin
    w_grant_write = w_req & (~r_req | w_write_first);
    w_grant_read  = r_req & ~w_grant_write;
  end

  // Access sequencer: outputs are loaded one cycle ahead of the state they
  // belong to, so every RAM strobe and ack comes straight from a flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= c_IDLE;
      w_ack     <= 1'b0;
      r_ack     <= 1'b0;
      r_data    <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      w_ack   <= 1'b0;
      r_ack   <= 1'b0;
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_grant_write) begin
            r_state   <= c_WR;
            mem_addr  <= w_addr;
            mem_wdata <= w_data;
            mem_wen   <= 1'b1;
            w_ack     <= 1'b1;
            busy      <= 1'b1;
          end else if (w_grant_read) begin
            r_state  <= c_RD;
            mem_addr <= r_addr;
            mem_ren  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        c_WR: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
        c_RD: begin
          r_state <= c_RD_WAIT;
        end
        c_RD_WAIT: begin
          r_data  <= mem_rdata;
          r_ack   <= 1'b1;
          r_state <= c_RESP;
        end
        c_RESP: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                           |
// | Purpose  : Directed, table-driven bench for mem_port_arbiter with a      |
// |            behavioural 8x8 synchronous RAM attached.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic       clk;
  logic       n_rst;
  logic       w_req;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       w_ack;
  logic       r_req;
  logic [2:0] r_addr;
  logic       r_ack;
  logic [7:0] r_data;
  logic [2:0] mem_addr;
  logic       mem_wen;
  logic       mem_ren;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  int checks;
  int errors;
  int n_wack;
  int n_rack;

  mem_port_arbiter #(.D_WIDTH(8), .A_WIDTH(3)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .w_req    (w_req),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_ack    (w_ack),
    .r_req    (r_req),
    .r_addr   (r_addr),
    .r_ack    (r_ack),
    .r_data   (r_data),
    .mem_addr (mem_addr),
    .mem_wen  (mem_wen),
    .mem_ren  (mem_ren),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data appears the cycle after mem_ren.
  logic [7:0] ram [8];
  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  // Ack pulse counters.
  initial begin
    n_wack = 0;
    n_rack = 0;
  end
  always @(negedge clk) begin
    if (w_ack) n_wack <= n_wack + 1;
    if (r_ack) n_rack <= n_rack + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction record: optional write (raised after w_dly cycles),
  // optional read, and the expected ack latencies counted in cycles from
  // the moment the requests are first driven while the arbiter is idle.
  typedef struct {
    logic       do_w;
    logic [2:0] wa;
    logic [7:0] wd;
    int         w_dly;
    int         w_lat;
    logic       do_r;
    logic [2:0] ra;
    logic [7:0] exp_rd;
    int         r_lat;
  } vec_t;

  vec_t vecs[22];

  task automatic run_vec(input vec_t v, input int idx);
    bit wdone;
    bit rdone;
    int wlat;
    int rlat;
    int wen_n;
    int ren_n;
    wdone = !v.do_w;
    rdone = !v.do_r;
    wlat = 0; rlat = 0; wen_n = 0; ren_n = 0;
    if (v.do_r) begin r_req = 1'b1; r_addr = v.ra; end
    if (v.do_w && v.w_dly == 0) begin w_req = 1'b1; w_addr = v.wa; w_data = v.wd; end
    for (int cyc = 1; cyc <= 30 && !(wdone && rdone); cyc++) begin
      @(negedge clk);
      chk($sformatf("v%0d ack_overlap", idx), {31'd0, w_ack & r_ack}, 32'd0);
      chk($sformatf("v%0d en_overlap", idx), {31'd0, mem_wen & mem_ren}, 32'd0);
      if (mem_wen) wen_n++;
      if (mem_ren) begin
        ren_n++;
        chk($sformatf("v%0d rd_mem_addr", idx), {29'd0, mem_addr}, {29'd0, v.ra});
      end
      if (w_ack) begin
        wlat = cyc; wdone = 1'b1;
        chk($sformatf("v%0d wr_wen", idx), {31'd0, mem_wen}, 32'd1);
        chk($sformatf("v%0d wr_addr", idx), {29'd0, mem_addr}, {29'd0, v.wa});
        chk($sformatf("v%0d wr_data", idx), {24'd0, mem_wdata}, {24'd0, v.wd});
        w_req = 1'b0;
      end
      if (r_ack) begin
        rlat = cyc; rdone = 1'b1;
        chk($sformatf("v%0d rd_data", idx), {24'd0, r_data}, {24'd0, v.exp_rd});
        r_req = 1'b0;
      end
      if (v.do_w && v.w_dly == cyc) begin
        w_req = 1'b1; w_addr = v.wa; w_data = v.wd;
      end
    end
    w_req = 1'b0;
    r_req = 1'b0;
    chk($sformatf("v%0d w_latency", idx), wlat, v.w_lat);
    chk($sformatf("v%0d r_latency", idx), rlat, v.r_lat);
    chk($sformatf("v%0d wen_pulses", idx), wen_n, {31'd0, v.do_w});
    chk($sformatf("v%0d ren_pulses", idx), ren_n, {31'd0, v.do_r});
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ord;
    logic [3:0] exp_ord;
    int         k;
    int         w0;
    int         r0;
    int         lat;

    checks = 0; errors = 0;
    n_rst = 1'b0;
    w_req = 1'b0; w_addr = '0; w_data = '0;
    r_req = 1'b0; r_addr = '0;

    // Stimulus table.
    vecs[0] = '{1'b1, 3'd2, 8'h5A, 0, 1, 1'b0, 3'd0, 8'h00, 0};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 0, 0, 1'b1, 3'd2, 8'h5A, 3};
    vecs[2] = '{1'b1, 3'd1, 8'h33, 0, 1, 1'b1, 3'd2, 8'h5A, 5};
    vecs[3] = '{1'b1, 3'd3, 8'h44, 2, 5, 1'b1, 3'd1, 8'h33, 3};
    for (int i = 0; i < 8; i++) begin
      vecs[4 + i]  = '{1'b1, 3'(i), 8'(8'h10 + i), 0, 1, 1'b0, 3'd0, 8'h00, 0};
      vecs[12 + i] = '{1'b0, 3'd0, 8'h00, 0, 0, 1'b1, 3'(i), 8'(8'h10 + i), 3};
    end
    vecs[20] = '{1'b1, 3'd0, 8'hAA, 0, 1, 1'b1, 3'd7, 8'h17, 5};
    vecs[21] = '{1'b0, 3'd0, 8'h00, 0, 0, 1'b1, 3'd0, 8'hAA, 3};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst w_ack", {31'd0, w_ack}, 32'd0);
    chk("rst r_ack", {31'd0, r_ack}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst mem_en", {30'd0, mem_wen, mem_ren}, 32'd0);
    chk("rst r_data", {24'd0, r_data}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Both requests held continuously: record the order of the first 4 acks.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = 4'b1010;
`else
    exp_ord = 4'b1111;
`endif
    ord = 4'b0000; k = 0;
    w_req = 1'b1; w_addr = 3'd6; w_data = 8'h66;
    r_req = 1'b1; r_addr = 3'd6;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      chk("cont ack_overlap", {31'd0, w_ack & r_ack}, 32'd0);
      if (w_ack) begin ord = {ord[2:0], 1'b1}; k++; end
      if (r_ack) begin ord = {ord[2:0], 1'b0}; k++; end
    end
    w_req = 1'b0; r_req = 1'b0;
    chk("cont grant_count", k, 4);
    chk("cont grant_order", {28'd0, ord}, {28'd0, exp_ord});
    @(negedge clk);
    chk("cont idle_busy", {31'd0, busy}, 32'd0);

    // Table: write/read, contention, request-while-busy, fill and dump.
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    w0 = n_wack; r0 = n_rack;
    for (int i = 4; i < 20; i++) run_vec(vecs[i], i);
    chk("fill w_ack_count", n_wack - w0, 8);
    chk("dump r_ack_count", n_rack - r0, 8);
    for (int i = 20; i < 22; i++) run_vec(vecs[i], i);

    // Reset during RD_WAIT, with the read request held through reset.
    r_req = 1'b1; r_addr = 3'd4;
    @(negedge clk);
    chk("mid rd mem_ren", {31'd0, mem_ren}, 32'd1);
    @(negedge clk);
    chk("mid rd_wait busy", {31'd0, busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("mid rst r_ack", {31'd0, r_ack}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst mem_addr", {29'd0, mem_addr}, 32'd0);
    chk("mid rst mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("mid rst r_data", {24'd0, r_data}, 32'd0);
    chk("mid rst mem_en", {30'd0, mem_wen, mem_ren}, 32'd0);
    @(negedge clk);
    chk("mid rst held r_ack", {31'd0, r_ack}, 32'd0);
    n_rst = 1'b1;
    lat = 0;
    for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
      @(negedge clk);
      if (r_ack) begin
        lat = cyc;
        chk("post rst r_data", {24'd0, r_data}, 32'h14);
        r_req = 1'b0;
      end
    end
    r_req = 1'b0;
    chk("post rst r_latency", lat, 3);
    @(negedge clk);
    chk("post rst idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
